switch_debouncer: RTL and testbench

- Input-side conditioner for the board slide switches. It is the reader end of the switch-to-LED datapath.
- Synchronizes raw asynchronous sw pins into clk and debounces each bit with a per-bit stability counter.
- Publishes the debounced vector as sw_out for downstream processing (add/blink style consumers).
- Emits change events (rise/fall masks) over a valid/ready handshake.

---
 rtl/switch_pkg.sv | 16 +
 rtl/debounce_bit.sv | 67 ++++++
 rtl/switch_debouncer.sv | 115 +++++++++++
 tb/tb_switch_debouncer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared constants for the slide-switch debouncer slice.
// Holds the default geometry, the production debounce interval and a short
// interval that keeps simulations fast.
package switch_pkg;

  localparam int SW_WIDTH_DEFAULT    = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int DEBOUNCE_CNT_WIDTH  = 20;

  // 10 ms of stable input at a 100 MHz system clock.
  localparam logic [DEBOUNCE_CNT_WIDTH-1:0] DEBOUNCE_10MS_100MHZ = 20'd1000000;

  // Short debounce interval for simulation builds.
  localparam logic [DEBOUNCE_CNT_WIDTH-1:0] DEBOUNCE_SIM_CYCLES  = 20'd8;

endpackage : switch_pkg

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer chain followed by a stability counter.
// The counter must see STABLE_CYCLES consecutive samples that differ from the
// current level before the level flips. Any sample that matches the level
// restarts the count. level_next exposes the value level takes at the next
// edge, so the parent can detect changes without an extra pipeline stage.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int                   SYNC_STAGES   = SYNC_STAGES_DEFAULT,  // >= 2
  parameter int                   CNT_WIDTH     = DEBOUNCE_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] STABLE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic level_next
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_level;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   w_level_next;
  logic                   w_s;

  // Plain shift chain: the first flop is the only one that can go metastable,
  // so nothing may sit between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Stability counter decision; the counter clears at the terminal count so it never wraps.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    if (w_s == r_level) begin
      w_cnt_next = '0;
    end else if (r_cnt == STABLE_CYCLES - CNT_WIDTH'(1)) begin
      w_level_next = ~r_level;
      w_cnt_next   = '0;
    end else begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1);
    end
  end

  // Register the counter and the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
    end
  end

  assign level      = r_level;
  assign level_next = w_level_next;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Switch input conditioner: per-bit synchronize + debounce, then publish
// change events (rise/fall masks plus a snapshot) over valid/ready.
// While an event waits for the consumer, further changes are merged into it.
// Build option: define SWITCH_DEBOUNCER_OVERRUN_EN to add the evt_overrun
// output, which flags that a pending event absorbed more than one change.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int                   WIDTH         = SW_WIDTH_DEFAULT,
  parameter int                   SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int                   CNT_WIDTH     = DEBOUNCE_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] STABLE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_rise,
  output logic [WIDTH-1:0] evt_fall
`ifdef SWITCH_DEBOUNCER_OVERRUN_EN
  ,
  output logic             evt_overrun
`endif
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_level_next;
  logic [WIDTH-1:0] w_chg_rise;
  logic [WIDTH-1:0] w_chg_fall;
  logic             w_chg;
  logic             w_accept;
  logic             w_load;
  logic             w_coalesce;

  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_data;
  logic [WIDTH-1:0] r_evt_rise;
  logic [WIDTH-1:0] r_evt_fall;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .SYNC_STAGES  (SYNC_STAGES),
        .CNT_WIDTH    (CNT_WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_debounce_bit (
        .clk       (clk),
        .rst       (rst),
        .raw       (sw_in[gi]),
        .level     (w_level[gi]),
        .level_next(w_level_next[gi])
      );
    end
  endgenerate

  assign sw_out = w_level;

  // Change masks look one edge ahead so the event lands together with sw_out.
  assign w_chg_rise = w_level_next & ~w_level;
  assign w_chg_fall = ~w_level_next & w_level;
  assign w_chg      = |(w_chg_rise | w_chg_fall);
  assign w_accept   = r_evt_valid & evt_ready;
  assign w_load     = w_chg & (~r_evt_valid | w_accept);
  assign w_coalesce = w_chg & r_evt_valid & ~w_accept;

  // Event register: fresh load, merge into a pending event, or retire on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_evt_rise  <= '0;
      r_evt_fall  <= '0;
    end else if (w_load) begin
      r_evt_valid <= 1'b1;
      r_evt_data  <= w_level_next;
      r_evt_rise  <= w_chg_rise;
      r_evt_fall  <= w_chg_fall;
    end else if (w_coalesce) begin
      r_evt_data  <= w_level_next;
      r_evt_rise  <= r_evt_rise | w_chg_rise;
      r_evt_fall  <= r_evt_fall | w_chg_fall;
    end else if (w_accept) begin
      r_evt_valid <= 1'b0;
      r_evt_rise  <= '0;
      r_evt_fall  <= '0;
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_data  = r_evt_data;
  assign evt_rise  = r_evt_rise;
  assign evt_fall  = r_evt_fall;

`ifdef SWITCH_DEBOUNCER_OVERRUN_EN
  logic r_evt_overrun;

  // Overrun belongs to the pending event: set by a merge, cleared by any accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_overrun <= 1'b0;
    end else if (w_coalesce) begin
      r_evt_overrun <= 1'b1;
    end else if (w_accept) begin
      r_evt_overrun <= 1'b0;
    end
  end

  assign evt_overrun = r_evt_overrun;
`endif

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with an 8-cycle debounce interval and a
// 2-flop synchronizer. Expected events are queued as stimulus is driven and
// popped when the DUT presents them.
module tb_switch_debouncer;
  import switch_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out;
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;
  logic [W-1:0] evt_rise;
  logic [W-1:0] evt_fall;
`ifdef SWITCH_DEBOUNCER_OVERRUN_EN
  logic         evt_overrun;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH        (W),
    .SYNC_STAGES  (2),
    .CNT_WIDTH    (DEBOUNCE_CNT_WIDTH),
    .STABLE_CYCLES(DEBOUNCE_SIM_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .sw_out     (sw_out),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .evt_rise   (evt_rise),
    .evt_fall   (evt_fall)
`ifdef SWITCH_DEBOUNCER_OVERRUN_EN
    ,
    .evt_overrun(evt_overrun)
`endif
  );

  task automatic apply_reset();
    sw_in     = '0;
    evt_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; sw_in = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({sw_out, evt_valid, evt_data, evt_rise, evt_fall} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got sw_out=%h valid=%b data=%h rise=%h fall=%h, expected all 0",
               sw_out, evt_valid, evt_data, evt_rise, evt_fall);
    end
    rst = 1'b0;
    @(negedge clk); sw_in = 4'hF;
    repeat (12) @(negedge clk);
    n_checks++;
    if ({sw_out, evt_valid, evt_rise} !== {4'hF, 1'b1, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_preload: got sw_out=%h valid=%b rise=%h, expected F 1 F", sw_out, evt_valid, evt_rise);
    end
    // asynchronous assertion between edges
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sw_out, evt_valid, evt_data, evt_rise, evt_fall} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got sw_out=%h valid=%b data=%h rise=%h fall=%h, expected all 0",
               sw_out, evt_valid, evt_data, evt_rise, evt_fall);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e = '{data: 4'hF, rise: 4'hF, fall: 4'h0, ovr: 1'b0};
    exp_q.push_back(e);
    repeat (9) @(negedge clk);
    n_checks++;
    if ({sw_out, evt_valid} !== {4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release_edge8: got sw_out=%h valid=%b, expected 0 0", sw_out, evt_valid);
    end
    @(negedge clk);
    n_checks++;
    if (sw_out !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release_edge9: got sw_out=%h, expected F", sw_out);
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL reset_event: no expected entry queued, valid=%b", evt_valid);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, e.data, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL reset_event: got valid=%b data=%h rise=%h fall=%h, expected 1 %h %h %h",
                 evt_valid, evt_data, evt_rise, evt_fall, e.data, e.rise, e.fall);
      end
      $display("event reset: data=%h rise=%h fall=%h", evt_data, evt_rise, evt_fall);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_accept: got valid=%b, expected 0", evt_valid);
    end
  endtask

  task automatic test_clean_toggle();
    exp_t e;
    apply_reset();
    evt_ready = 1'b1;
    @(negedge clk); sw_in = 4'h1;
    e = '{data: 4'h1, rise: 4'h1, fall: 4'h0, ovr: 1'b0};
    exp_q.push_back(e);
    repeat (9) @(negedge clk);
    n_checks++;
    if ({sw_out, evt_valid} !== {4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL toggle_edge8: got sw_out=%h valid=%b, expected 0 0", sw_out, evt_valid);
    end
    @(negedge clk);
    n_checks++;
    if (sw_out !== 4'h1) begin
      n_fail++;
      $display("FAIL toggle_edge9: got sw_out=%h, expected 1", sw_out);
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL toggle_event: no expected entry queued, valid=%b", evt_valid);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, e.data, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL toggle_event: got valid=%b data=%h rise=%h fall=%h, expected 1 %h %h %h",
                 evt_valid, evt_data, evt_rise, evt_fall, e.data, e.rise, e.fall);
      end
      $display("event toggle: data=%h rise=%h fall=%h", evt_data, evt_rise, evt_fall);
    end
    @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b0, 4'h1, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL toggle_pulse_end: got valid=%b data=%h rise=%h fall=%h, expected 0 1 0 0",
               evt_valid, evt_data, evt_rise, evt_fall);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    logic seen;
    seen = 1'b0;
    apply_reset();
    evt_ready = 1'b1;
    @(negedge clk); sw_in = 4'h4;
    for (int i = 0; i < 20; i++) begin
      if (i == 7) sw_in = 4'h0;
      @(negedge clk);
      if (evt_valid || sw_out != 4'h0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_rejected: got activity=%b, expected 0 (sw_out=%h data=%h)", seen, sw_out, evt_data);
    end
    sw_in = 4'h4;
    e = '{data: 4'h4, rise: 4'h4, fall: 4'h0, ovr: 1'b0};
    exp_q.push_back(e);
    repeat (10) @(negedge clk);
    n_checks++;
    if (sw_out !== 4'h4) begin
      n_fail++;
      $display("FAIL glitch_held_level: got sw_out=%h, expected 4", sw_out);
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL glitch_event: no expected entry queued, valid=%b", evt_valid);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, e.data, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL glitch_event: got valid=%b data=%h rise=%h fall=%h, expected 1 %h %h %h",
                 evt_valid, evt_data, evt_rise, evt_fall, e.data, e.rise, e.fall);
      end
      $display("event glitch: data=%h rise=%h fall=%h", evt_data, evt_rise, evt_fall);
    end
  endtask

  task automatic test_coalesce();
    exp_t e;
    apply_reset();
    @(negedge clk); sw_in = 4'h2;
    e = '{data: 4'h8, rise: 4'hA, fall: 4'h2, ovr: 1'b1};
    exp_q.push_back(e);
    repeat (10) @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, 4'h2, 4'h2, 4'h0}) begin
      n_fail++;
      $display("FAIL coalesce_first: got valid=%b data=%h rise=%h fall=%h, expected 1 2 2 0",
               evt_valid, evt_data, evt_rise, evt_fall);
    end
    repeat (10) @(negedge clk); sw_in = 4'hA;
    repeat (20) @(negedge clk); sw_in = 4'h8;
    repeat (12) @(negedge clk);
    n_checks++;
    if (sw_out !== 4'h8) begin
      n_fail++;
      $display("FAIL coalesce_sw_out: got sw_out=%h, expected 8", sw_out);
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL coalesce_event: no expected entry queued, valid=%b", evt_valid);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, e.data, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL coalesce_event: got valid=%b data=%h rise=%h fall=%h, expected 1 %h %h %h",
                 evt_valid, evt_data, evt_rise, evt_fall, e.data, e.rise, e.fall);
      end
`ifdef SWITCH_DEBOUNCER_OVERRUN_EN
      n_checks++;
      if (evt_overrun !== e.ovr) begin
        n_fail++;
        $display("FAIL coalesce_overrun: got %b, expected %b", evt_overrun, e.ovr);
      end
`endif
      $display("event coalesce: data=%h rise=%h fall=%h", evt_data, evt_rise, evt_fall);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, 4'h8, 4'hA, 4'h2}) begin
      n_fail++;
      $display("FAIL coalesce_hold: got valid=%b data=%h rise=%h fall=%h, expected 1 8 A 2",
               evt_valid, evt_data, evt_rise, evt_fall);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b0, 4'h8, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL coalesce_accept: got valid=%b data=%h rise=%h fall=%h, expected 0 8 0 0",
               evt_valid, evt_data, evt_rise, evt_fall);
    end
`ifdef SWITCH_DEBOUNCER_OVERRUN_EN
    n_checks++;
    if (evt_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL coalesce_overrun_clear: got %b, expected 0", evt_overrun);
    end
`endif
  endtask

  task automatic test_simultaneous();
    exp_t e;
    apply_reset();
    @(negedge clk); sw_in = 4'h1;
    e = '{data: 4'h1, rise: 4'h1, fall: 4'h0, ovr: 1'b0};
    exp_q.push_back(e);
    repeat (20) @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL simul_first_event: no expected entry queued, valid=%b", evt_valid);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, e.data, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL simul_first_event: got valid=%b data=%h rise=%h fall=%h, expected 1 %h %h %h",
                 evt_valid, evt_data, evt_rise, evt_fall, e.data, e.rise, e.fall);
      end
      $display("event simul_first: data=%h rise=%h fall=%h", evt_data, evt_rise, evt_fall);
    end
    sw_in = 4'h3;
    e = '{data: 4'h3, rise: 4'h2, fall: 4'h0, ovr: 1'b0};
    exp_q.push_back(e);
    repeat (9) @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_data, evt_rise, sw_out} !== {1'b1, 4'h1, 4'h1, 4'h1}) begin
      n_fail++;
      $display("FAIL simul_pre_edge: got valid=%b data=%h rise=%h sw_out=%h, expected 1 1 1 1",
               evt_valid, evt_data, evt_rise, sw_out);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sw_out !== 4'h3) begin
      n_fail++;
      $display("FAIL simul_sw_out: got sw_out=%h, expected 3", sw_out);
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL simul_second_event: no expected entry queued, valid=%b", evt_valid);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, e.data, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL simul_second_event: got valid=%b data=%h rise=%h fall=%h, expected 1 %h %h %h",
                 evt_valid, evt_data, evt_rise, evt_fall, e.data, e.rise, e.fall);
      end
`ifdef SWITCH_DEBOUNCER_OVERRUN_EN
      n_checks++;
      if (evt_overrun !== e.ovr) begin
        n_fail++;
        $display("FAIL simul_overrun: got %b, expected %b", evt_overrun, e.ovr);
      end
`endif
      $display("event simul_second: data=%h rise=%h fall=%h", evt_data, evt_rise, evt_fall);
    end
    @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_accept: got valid=%b, expected 0", evt_valid);
    end
  endtask

  task automatic test_reset_midcount();
    exp_t e;
    apply_reset();
    evt_ready = 1'b1;
    @(negedge clk); sw_in = 4'h1;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({sw_out, evt_valid} !== {4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL midcount_after_pulse: got sw_out=%h valid=%b, expected 0 0", sw_out, evt_valid);
    end
    e = '{data: 4'h1, rise: 4'h1, fall: 4'h0, ovr: 1'b0};
    exp_q.push_back(e);
    repeat (9) @(negedge clk);
    n_checks++;
    if (sw_out !== 4'h0) begin
      n_fail++;
      $display("FAIL midcount_edge8: got sw_out=%h, expected 0", sw_out);
    end
    @(negedge clk);
    n_checks++;
    if (sw_out !== 4'h1) begin
      n_fail++;
      $display("FAIL midcount_edge9: got sw_out=%h, expected 1", sw_out);
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL midcount_event: no expected entry queued, valid=%b", evt_valid);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_data, evt_rise, evt_fall} !== {1'b1, e.data, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL midcount_event: got valid=%b data=%h rise=%h fall=%h, expected 1 %h %h %h",
                 evt_valid, evt_data, evt_rise, evt_fall, e.data, e.rise, e.fall);
      end
      $display("event midcount: data=%h rise=%h fall=%h", evt_data, evt_rise, evt_fall);
    end
  endtask

  initial begin
    test_reset();
    test_clean_toggle();
    test_glitch();
    test_coalesce();
    test_simultaneous();
    test_reset_midcount();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d unmatched entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_switch_debouncer
